// File: rtl/ac_xor_sequencer.sv
// rtl/ac_xor_sequencer.sv - operand sequencer and result accumulator for the 8-bit XOR stage
//
// Launches registered operands into the gate-level XOR stage, waits a fixed
// number of clock edges for the NAND network to settle, then captures the
// stage output into the accumulator.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   in_valid/in_ready command handshake; in_op 00 LOAD, 01 XOR, 10 CLEAR, 11 NOP
//   in_data           command operand
//   xor_a, xor_b      registered operands driven into the XOR stage
//   xor_c             XOR stage result, sampled only at the capture edge
//   acc               accumulator
//   done              one-cycle pulse per retired command
//   op_count          retired-command counter, wraps 255 -> 0
module ac_xor_sequencer #(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [1:0] in_op,
    input  logic [7:0] in_data,
    output logic [7:0] xor_a,
    output logic [7:0] xor_b,
    input  logic [7:0] xor_c,
    output logic [7:0] acc,
    output logic       done,
    output logic [7:0] op_count
);

    localparam logic [1:0] OP_LOAD  = 2'b00;
    localparam logic [1:0] OP_XOR   = 2'b01;
    localparam logic [1:0] OP_CLEAR = 2'b10;
    localparam logic [1:0] OP_NOP   = 2'b11;

    // The counter runs from SETTLE_CYCLES-1 down to 0; capture happens on the
    // edge that finds it at 0, i.e. SETTLE_CYCLES edges after the launch.
    localparam logic [3:0] SETTLE_INIT = 4'(SETTLE_CYCLES - 1);

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_SETTLE = 1'b1
    } state_t;

    state_t     r_state;
    state_t     w_state_next;
    logic [3:0] r_settle;
    logic [3:0] w_settle_next;
    logic [7:0] r_acc;
    logic [7:0] w_acc_next;
    logic [7:0] r_xor_a;
    logic [7:0] w_xor_a_next;
    logic [7:0] r_xor_b;
    logic [7:0] w_xor_b_next;
    logic       r_done;
    logic       w_done_next;
    logic [7:0] r_op_count;
    logic [7:0] w_op_count_next;
    logic       w_accept;

    // Gated with rst_n so the handshake reads not-ready while reset is held,
    // even though the state register already sits at IDLE.
    assign in_ready = rst_n & (r_state == S_IDLE);
    assign w_accept = in_valid & (r_state == S_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_settle   <= 4'd0;
            r_acc      <= 8'd0;
            r_xor_a    <= 8'd0;
            r_xor_b    <= 8'd0;
            r_done     <= 1'b0;
            r_op_count <= 8'd0;
        end else begin
            r_state    <= w_state_next;
            r_settle   <= w_settle_next;
            r_acc      <= w_acc_next;
            r_xor_a    <= w_xor_a_next;
            r_xor_b    <= w_xor_b_next;
            r_done     <= w_done_next;
            r_op_count <= w_op_count_next;
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_settle_next = r_settle;
        w_acc_next    = r_acc;
        w_xor_a_next  = r_xor_a;
        w_xor_b_next  = r_xor_b;
        w_done_next   = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    case (in_op)
                        OP_LOAD: begin
                            w_acc_next  = in_data;
                            w_done_next = 1'b1;
                        end
                        OP_XOR: begin
                            w_xor_a_next  = r_acc;
                            w_xor_b_next  = in_data;
                            w_settle_next = SETTLE_INIT;
                            w_state_next  = S_SETTLE;
                        end
                        OP_CLEAR: begin
                            w_acc_next  = 8'd0;
                            w_done_next = 1'b1;
                        end
                        OP_NOP: begin
                            w_done_next = 1'b1;
                        end
                        default: begin
                        end
                    endcase
                end
            end
            S_SETTLE: begin
                // Operands stay frozen here; xor_c is only looked at on the
                // final edge so glitches while the network settles are harmless.
                if (r_settle != 4'd0) begin
                    w_settle_next = r_settle - 4'd1;
                end else begin
                    w_acc_next   = xor_c;
                    w_done_next  = 1'b1;
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase

        w_op_count_next = w_done_next ? r_op_count + 8'd1 : r_op_count;
    end

    assign xor_a    = r_xor_a;
    assign xor_b    = r_xor_b;
    assign acc      = r_acc;
    assign done     = r_done;
    assign op_count = r_op_count;

endmodule

// File: tb/tb_ac_xor_sequencer.sv
// tb/tb_ac_xor_sequencer.sv - self-checking bench for ac_xor_sequencer at settle 2, 1 and 15
module tb_ac_xor_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       v   [3];
    logic [1:0] op  [3];
    logic [7:0] d   [3];
    logic [7:0] xc  [3];
    logic       rdy [3];
    logic [7:0] xa  [3];
    logic [7:0] xb  [3];
    logic [7:0] acc [3];
    logic       dn  [3];
    logic [7:0] cnt [3];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        ac_xor_sequencer #(
            .SETTLE_CYCLES((g == 0) ? 2 : ((g == 1) ? 1 : 15))
        ) u_dut (
            .clk      (clk),
            .rst_n    (rst_n),
            .in_valid (v[g]),
            .in_ready (rdy[g]),
            .in_op    (op[g]),
            .in_data  (d[g]),
            .xor_a    (xa[g]),
            .xor_b    (xb[g]),
            .xor_c    (xc[g]),
            .acc      (acc[g]),
            .done     (dn[g]),
            .op_count (cnt[g])
        );
    end

    int     checks = 0;
    int     errors = 0;
    longint cyc = 0;
    int     sc [3] = '{2, 1, 15};

    // Reference model: plain values plus "capture happens at accept edge + S".
    int     m_acc  [3];
    int     m_a    [3];
    int     m_b    [3];
    int     m_cnt  [3];
    bit     m_done [3];
    bit     m_busy [3];
    longint cap_at [3];
    int     ndone  [3];

    logic [9:0] cbuf [3][1024];
    int         qh [3];
    int         qt [3];

    task automatic chk(input string name, input int k, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s[%0d] got %0h expected %0h at cycle %0d", name, k, act, exp, cyc);
        end
    endtask

    task automatic push(input int k, input int o, input int dd);
        logic [1:0] o2;
        logic [7:0] d8;
        o2 = o[1:0];
        d8 = dd[7:0];
        cbuf[k][qt[k] % 1024] = {o2, d8};
        qt[k]++;
    endtask

    task automatic push_all(input int o, input int dd);
        for (int k = 0; k < 3; k++) push(k, o, dd);
    endtask

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            m_acc[k] = 0; m_a[k] = 0; m_b[k] = 0; m_cnt[k] = 0;
            m_done[k] = 0; m_busy[k] = 0; cap_at[k] = 0;
            qh[k] = 0; qt[k] = 0;
        end
    endtask

    task automatic model_edge(input int k);
        m_done[k] = 0;
        if (m_busy[k]) begin
            if (cyc == cap_at[k]) begin
                m_acc[k]  = m_a[k] ^ m_b[k];
                m_done[k] = 1;
                m_busy[k] = 0;
            end
        end else if (v[k]) begin
            qh[k]++;
            case (op[k])
                2'd0: begin m_acc[k] = int'(d[k]); m_done[k] = 1; end
                2'd1: begin
                    m_a[k] = m_acc[k]; m_b[k] = int'(d[k]);
                    m_busy[k] = 1; cap_at[k] = cyc + sc[k];
                end
                2'd2: begin m_acc[k] = 0; m_done[k] = 1; end
                default: m_done[k] = 1;
            endcase
        end
        if (m_done[k]) m_cnt[k] = (m_cnt[k] + 1) % 256;
    endtask

    task automatic compare_all();
        for (int k = 0; k < 3; k++) begin
            chk("in_ready", k, int'(rdy[k]), int'(rst_n && !m_busy[k]));
            chk("acc",      k, int'(acc[k]), m_acc[k]);
            chk("xor_a",    k, int'(xa[k]),  m_a[k]);
            chk("xor_b",    k, int'(xb[k]),  m_b[k]);
            chk("done",     k, int'(dn[k]),  int'(m_done[k]));
            chk("op_count", k, int'(cnt[k]), m_cnt[k]);
            if (dn[k]) ndone[k]++;
        end
    endtask

    task automatic drive_inputs(input bit gaps);
        logic [9:0] c;
        for (int k = 0; k < 3; k++) begin
            if (qh[k] != qt[k] && (!gaps || $urandom_range(3) != 0)) begin
                c     = cbuf[k][qh[k] % 1024];
                v[k]  = 1'b1;
                op[k] = c[9:8];
                d[k]  = c[7:0];
            end else begin
                v[k]  = 1'b0;
                op[k] = 2'($urandom);
                d[k]  = 8'($urandom);
            end
            // Stage output is only correct just before the capture edge; any
            // other time it carries noise that must not reach the accumulator.
            if (m_busy[k] && cap_at[k] == cyc + 1) xc[k] = 8'(m_a[k] ^ m_b[k]);
            else                                  xc[k] = 8'($urandom);
        end
    endtask

    task automatic step(input bit gaps);
        drive_inputs(gaps);
        @(posedge clk);
        cyc++;
        if (rst_n) for (int k = 0; k < 3; k++) model_edge(k);
        @(negedge clk);
        compare_all();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        for (int k = 0; k < 3; k++) begin
            v[k] = 1'b1; op[k] = 2'd0; d[k] = 8'hFF; xc[k] = 8'h00;
        end
        #1;
        compare_all();
        repeat (2) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            compare_all();
        end
        for (int k = 0; k < 3; k++) v[k] = 1'b0;
        rst_n = 1'b1;
        #1;
        compare_all();
    endtask

    task automatic drain(input bit gaps);
        int  n;
        bit  pending;
        n = 0;
        pending = 1;
        while (pending && n < 6000) begin
            pending = 0;
            for (int k = 0; k < 3; k++)
                if (qh[k] != qt[k] || m_busy[k]) pending = 1;
            if (pending) begin
                step(gaps);
                n++;
            end
        end
        chk("drain_timeout", 0, int'(pending), 0);
    endtask

    initial begin
        rst_n = 1'b0;
        for (int k = 0; k < 3; k++) begin
            v[k] = 1'b1; op[k] = 2'd0; d[k] = 8'h00; xc[k] = 8'h00; ndone[k] = 0;
        end
        model_reset();
        @(negedge clk);

        // Reset with in_valid high, then release.
        do_reset();
        chk("reset_acc", 0, int'(acc[0]), 0);
        chk("reset_ready_after_release", 0, int'(rdy[0]), 1);

        // LOAD A5 then XOR 0F.
        push_all(0, 'hA5);
        push_all(1, 'h0F);
        step(0);
        chk("lit_load_acc", 0, int'(acc[0]), 'hA5);
        chk("lit_load_done", 0, int'(dn[0]), 1);
        step(0);
        chk("lit_xor_a", 0, int'(xa[0]), 'hA5);
        chk("lit_xor_b", 0, int'(xb[0]), 'h0F);
        chk("lit_ready_low1", 0, int'(rdy[0]), 0);
        step(0);
        chk("lit_ready_low2", 0, int'(rdy[0]), 0);
        chk("lit_s1_capture", 1, int'(acc[1]), 'hAA);
        chk("lit_s1_done", 1, int'(dn[1]), 1);
        step(0);
        chk("lit_s2_capture", 0, int'(acc[0]), 'hAA);
        chk("lit_s2_done", 0, int'(dn[0]), 1);
        chk("lit_s2_ready", 0, int'(rdy[0]), 1);
        drain(0);
        for (int k = 0; k < 3; k++) begin
            chk("lit_xor_final", k, int'(acc[k]), 'hAA);
            chk("lit_xor_count", k, int'(cnt[k]), 2);
        end

        // Back-to-back LOAD 11, CLEAR, NOP.
        do_reset();
        push_all(0, 'h11);
        push_all(2, 0);
        push_all(3, 0);
        step(0);
        chk("lit_b2b_acc1", 0, int'(acc[0]), 'h11);
        chk("lit_b2b_done1", 0, int'(dn[0]), 1);
        step(0);
        chk("lit_b2b_acc2", 0, int'(acc[0]), 'h00);
        chk("lit_b2b_done2", 0, int'(dn[0]), 1);
        step(0);
        chk("lit_b2b_acc3", 0, int'(acc[0]), 'h00);
        chk("lit_b2b_done3", 0, int'(dn[0]), 1);
        chk("lit_b2b_count", 0, int'(cnt[0]), 3);
        step(0);
        chk("lit_b2b_done_drop", 0, int'(dn[0]), 0);

        // Second XOR held pending while the first settles.
        push_all(0, 'hA5);
        push_all(1, 'h0F);
        push_all(1, 'hFF);
        drain(0);
        for (int k = 0; k < 3; k++) chk("lit_pending_xor", k, int'(acc[k]), 'h55);

        // Reset one cycle into SETTLE.
        do_reset();
        push_all(1, 'h33);
        step(0);
        step(0);
        do_reset();
        chk("lit_midrst_acc", 0, int'(acc[0]), 0);
        chk("lit_midrst_cnt", 0, int'(cnt[0]), 0);
        chk("lit_midrst_done", 0, int'(dn[0]), 0);
        repeat (3) step(0);
        push_all(0, 'h3C);
        drain(0);
        for (int k = 0; k < 3; k++) begin
            chk("lit_post_rst_load", k, int'(acc[k]), 'h3C);
            chk("lit_post_rst_cnt", k, int'(cnt[k]), 1);
        end

        // 256 NOPs wrap the counter.
        do_reset();
        for (int k = 0; k < 3; k++) ndone[k] = 0;
        for (int i = 0; i < 256; i++) push_all(3, 0);
        drain(0);
        step(0);
        for (int k = 0; k < 3; k++) begin
            chk("lit_wrap_count", k, int'(cnt[k]), 0);
            chk("lit_wrap_dones", k, ndone[k], 256);
        end

        // Randomized traffic with idle gaps.
        for (int i = 0; i < 400; i++)
            for (int k = 0; k < 3; k++)
                push(k, int'($urandom_range(3)), int'($urandom_range(255)));
        drain(1);
        repeat (4) step(1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
